mem_stage_ws: RTL and testbench

Parametrised MIPS MEM stage with a wait-state data memory, range and alignment checking, and a pipeline stall output. It sits between the EXE/MEM and MEM/WB pipeline registers. It maps the ALU byte address onto a word-indexed local array and takes a configurable number of cycles per access. `mem_freeze` holds the rest of the pipeline for the duration of each access. Illegal accesses raise a single-cycle `mem_fault` without stalling.

---
 rtl/mem_stage_ws.sv | 138 +++++++++++++
 tb/tb_mem_stage_ws.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ws.sv
// mem_stage_ws: MIPS MEM stage with a wait-state word-addressed data memory.
//
// A valid load or store is accepted in IDLE. The block then spends
// WAIT_STATES+1 cycles in BUSY and one cycle in DONE. mem_freeze stalls the
// pipeline from the request cycle through the last BUSY cycle. An illegal
// request raises mem_fault for as long as it is present in IDLE and does not
// stall the pipeline.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   MEM_R_EN_in    load request
//   MEM_W_EN_in    store request
//   ALU_result_in  byte address
//   ST_val         store data
//   mem_freeze     combinational stall request
//   Mem_read_value registered load data, updated only when a load completes
//   mem_fault      combinational illegal-access flag
module mem_stage_ws #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN_in,
    input  logic        MEM_W_EN_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] ST_val,
    output logic        mem_freeze,
    output logic [31:0] Mem_read_value,
    output logic        mem_fault
);

    localparam int unsigned CNT_W = (WAIT_STATES == 0) ? 1 : $clog2(WAIT_STATES + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rd_q, rd_d;
    logic [31:0]        mem_q [DEPTH];

    logic [31:0]        offset;
    logic [IDX_W-1:0]   idx;
    logic               req;
    logic               acc_valid;
    logic               mem_we;
    logic               freeze_c;
    logic               fault_c;

    // Address decode; the subtraction wraps, so the below-base check stands alone
    assign offset    = ALU_result_in - 32'(BASE_ADDR);
    assign idx       = offset[IDX_W+1:2];
    assign req       = MEM_R_EN_in | MEM_W_EN_in;
    assign acc_valid = (ALU_result_in >= 32'(BASE_ADDR))
                     && ((offset >> 2) < 32'(DEPTH))
                     && (ALU_result_in[1:0] == 2'b00)
                     && !(MEM_R_EN_in && MEM_W_EN_in);

    // State, wait counter and load data register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

    // Next state, access strobes and stall/fault flags
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        mem_we   = 1'b0;
        freeze_c = 1'b0;
        fault_c  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (acc_valid) begin
                        freeze_c = 1'b1;
                        cnt_d    = CNT_W'(WAIT_STATES);
                        state_d  = S_BUSY;
                    end else begin
                        fault_c  = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                freeze_c = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Access edge: inputs are held stable by the frozen pipeline
                    state_d = S_DONE;
                    if (MEM_W_EN_in) begin
                        mem_we = 1'b1;
                    end else begin
                        rd_d = mem_q[idx];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Flags are forced low while reset is held, whatever the inputs
        if (!rst) begin
            freeze_c = 1'b0;
            fault_c  = 1'b0;
        end
    end

    // Data array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= ST_val;
        end
    end

    assign mem_freeze     = freeze_c;
    assign mem_fault      = fault_c;
    assign Mem_read_value = rd_q;

endmodule

// File: tb/tb_mem_stage_ws.sv
// Bench for mem_stage_ws: a WAIT_STATES=2 instance and a WAIT_STATES=0 instance
// share one set of input drivers; sel picks whose outputs are observed.
module tb_mem_stage_ws;

    logic        clk = 1'b0;
    logic        rst;
    logic        re, we;
    logic [31:0] addr, stv;

    logic        frz_a, flt_a, frz_b, flt_b;
    logic [31:0] rdv_a, rdv_b;

    logic        sel;
    logic        frz, flt;
    logic [31:0] rdv;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd;
    logic [31:0] sb [$];
    logic        pat [$];

    always #5 clk = ~clk;

    mem_stage_ws #(.BASE_ADDR(1024), .DEPTH(64), .WAIT_STATES(2)) dut_a (
        .clk(clk), .rst(rst), .MEM_R_EN_in(re), .MEM_W_EN_in(we),
        .ALU_result_in(addr), .ST_val(stv),
        .mem_freeze(frz_a), .Mem_read_value(rdv_a), .mem_fault(flt_a)
    );

    mem_stage_ws #(.BASE_ADDR(1024), .DEPTH(64), .WAIT_STATES(0)) dut_b (
        .clk(clk), .rst(rst), .MEM_R_EN_in(re), .MEM_W_EN_in(we),
        .ALU_result_in(addr), .ST_val(stv),
        .mem_freeze(frz_b), .Mem_read_value(rdv_b), .mem_fault(flt_b)
    );

    assign frz = sel ? frz_b : frz_a;
    assign flt = sel ? flt_b : flt_a;
    assign rdv = sel ? rdv_b : rdv_a;

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_fault;
        logic [31:0] exp_rd;
        string       name;
    } vec_t;

    vec_t tab [14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // One access: drive after the edge, sample each cycle on the falling edge
    task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic exp_fault,
                              input logic [31:0] exp_rd, input string nm);
        int n;
        logic [31:0] e;
        @(posedge clk); #1;
        re = r; we = w; addr = a; stv = d;
        @(negedge clk);
        if (exp_fault) begin
            check({nm, " fault"}, 32'(flt), 32'd1);
            check({nm, " no freeze"}, 32'(frz), 32'd0);
            check({nm, " rd held"}, rdv, last_rd);
            @(posedge clk); #1;
            re = 1'b0; we = 1'b0;
            @(negedge clk);
            check({nm, " fault drops"}, 32'(flt), 32'd0);
            return;
        end
        check({nm, " no fault"}, 32'(flt), 32'd0);
        if (r) sb.push_back(exp_rd);
        n = 0;
        while (frz && n < 40) begin
            n++;
            pat.push_back(1'b1);
            @(negedge clk);
        end
        pat.push_back(1'b0);
        check({nm, " freeze cycles"}, 32'(n), sel ? 32'd2 : 32'd4);
        if (r) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL %s scoreboard: got empty queue expected one entry", nm);
            end else begin
                e = sb.pop_front();
                check({nm, " read data"}, rdv, e);
                last_rd = e;
            end
        end else begin
            check({nm, " rd held"}, rdv, last_rd);
        end
    endtask

    initial begin
        logic [9:0] p;
        tab[0]  = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, 32'h0,        "st 1028"};
        tab[1]  = '{1'b1, 1'b0, 32'd1028, 32'h0,        1'b0, 32'hDEADBEEF, "ld 1028"};
        tab[2]  = '{1'b1, 1'b0, 32'd1020, 32'h0,        1'b1, 32'h0,        "ld 1020"};
        tab[3]  = '{1'b1, 1'b0, 32'd1030, 32'h0,        1'b1, 32'h0,        "ld 1030"};
        tab[4]  = '{1'b1, 1'b1, 32'd1028, 32'h0,        1'b1, 32'h0,        "both en"};
        tab[5]  = '{1'b0, 1'b1, 32'd1276, 32'h12345678, 1'b0, 32'h0,        "st 1276"};
        tab[6]  = '{1'b1, 1'b0, 32'd1276, 32'h0,        1'b0, 32'h12345678, "ld 1276"};
        tab[7]  = '{1'b0, 1'b1, 32'd1280, 32'hAAAAAAAA, 1'b1, 32'h0,        "st 1280"};
        tab[8]  = '{1'b1, 1'b0, 32'd1276, 32'h0,        1'b0, 32'h12345678, "ld 1276 again"};
        tab[9]  = '{1'b1, 1'b0, 32'h0,    32'h0,        1'b1, 32'h0,        "ld 0"};
        tab[10] = '{1'b0, 1'b1, 32'd1024, 32'h11,       1'b0, 32'h0,        "st 1024"};
        tab[11] = '{1'b0, 1'b1, 32'd1028, 32'h22,       1'b0, 32'h0,        "st 1028 b"};
        tab[12] = '{1'b0, 1'b1, 32'd1032, 32'h55,       1'b0, 32'h0,        "st 1032"};
        tab[13] = '{1'b1, 1'b0, 32'd1032, 32'h0,        1'b0, 32'h55,       "ld 1032"};

        sel = 1'b0;
        last_rd = 32'h0;
        rst = 1'b0;
        re = 1'b1; we = 1'b1; addr = 32'd1020; stv = 32'h0;

        // Reset forces the flags low even with live requests
        #12;
        check("rst fault forced", 32'(flt_a), 32'd0);
        check("rst rd a", rdv_a, 32'h0);
        check("rst rd b", rdv_b, 32'h0);
        we = 1'b0; addr = 32'd1028;
        #2;
        check("rst freeze forced", 32'(frz_a), 32'd0);
        check("rst freeze forced b", 32'(frz_b), 32'd0);
        re = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_access(tab[i].r, tab[i].w, tab[i].addr, tab[i].data,
                       tab[i].exp_fault, tab[i].exp_rd, tab[i].name);
        end

        // Back-to-back loads: freeze must read 1111 0 1111 0
        pat.delete();
        run_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 32'h11, "b2b ld 1024");
        run_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, 32'h22, "b2b ld 1028");
        p = '0;
        for (int i = 0; i < 10 && i < pat.size(); i++) p[9-i] = pat[i];
        check("b2b pattern len", 32'(pat.size()), 32'd10);
        check("b2b pattern", 32'(p), 32'(10'b1111011110));

        // Reset during the second BUSY cycle of a store aborts it
        @(posedge clk); #1;
        re = 1'b0; we = 1'b1; addr = 32'd1032; stv = 32'h01;
        @(posedge clk);
        @(posedge clk); #2;
        check("abort in busy", 32'(frz), 32'd1);
        rst = 1'b0;
        #1;
        check("abort freeze", 32'(frz), 32'd0);
        check("abort rd cleared", rdv, 32'h0);
        check("abort fault", 32'(flt), 32'd0);
        we = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        last_rd = 32'h0;
        run_access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, 32'h55, "ld 1032 after abort");

        // Zero wait states: reset both, then observe the second instance
        @(posedge clk); #1;
        re = 1'b0; we = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        last_rd = 32'h0;
        sel = 1'b1;
        @(negedge clk);
        check("ws0 rd after reset", rdv, 32'h0);
        run_access(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 1'b0, 32'h0, "ws0 st 1040");
        run_access(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, 32'hCAFEF00D, "ws0 ld 1040");
        run_access(1'b1, 1'b0, 32'd1280, 32'h0, 1'b1, 32'h0, "ws0 ld 1280");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
